ring_rr_arbiter: RTL
====================

// Module: ring_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one resource among N requesters.
//   Priority is held in a one-hot ring pointer that rotates like the team's ring_counter.
//   Grants are one-hot with a bounded hold time, and ownership hands over back-to-back with no idle bubble.
//   Sits between N client request lines and the shared resource mux/enable.
// PARAMETERS
//   N         8   number of requesters (>=2)
//   MAX_HOLD  4   max consecutive cycles one requester may own the grant (>=1)
// PORTS
//   clk        in   1            single clock, all state updates on posedge
//   reset      in   1            synchronous, active-low reset (0 at posedge = reset)
//   req        in   N            request per client, level, held until served/done
//   gnt        out  N            one-hot grant (or all-zero), registered
//   gnt_valid  out  1            |gnt, registered
//   gnt_id     out  $clog2(N)    index of granted client; 0 when gnt_valid=0
//   ptr        out  N            one-hot ring priority pointer (search start)
// BEHAVIOUR
//   - Reset (reset==0 at posedge): gnt=0, gnt_valid=0, gnt_id=0, ptr=1 (bit0), state=IDLE, hold_cnt=0.
//     Reset wins over every other event, including mid-grant.
//   - FSM states: IDLE, GRANT.
//   - Pick function: first i with req[i]=1, searching circularly upward from the ptr bit.
//   - IDLE:
//     - |req=1 -> gnt=onehot(pick) next edge (1-cycle latency); ->GRANT; hold_cnt=0.
//     - Otherwise stay IDLE with all outputs zero.
//   - GRANT, owner o:
//     - release = !req[o] || hold_cnt==MAX_HOLD-1.
//     - No release: gnt unchanged, hold_cnt++.
//     - On release: ptr <= rotate-left of onehot(o), so bit o+1, wrapping N-1 -> 0.
//       Pick is evaluated from that new ptr using the req of the same cycle.
//       - Requester found: gnt=new one-hot next edge, hold_cnt=0, stay GRANT (no bubble).
//       - None found: gnt=0, ->IDLE.
//     - Owner still requesting after MAX_HOLD: it is re-granted only if no other req is set (search wraps back to o).
//   - ptr changes only on release or reset. It is always exactly one-hot.
//   - gnt is always one-hot or zero and never grants a client whose req was 0 in the deciding cycle.
//   - Grant changes only at a posedge. There is no combinational path req -> gnt.
//   - hold_cnt width is $clog2(MAX_HOLD)+1. It never exceeds MAX_HOLD-1.
//   - MAX_HOLD=1: the grant rotates every cycle while multiple requesters are active.
// STRUCTURE
//   - Shared package ring_arb_pkg:
//     - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1;
//     - function onehot2idx.
//   - One sub-module, rr_pick: combinational circular priority picker.
//     - Inputs: req[N], ptr[N]. Outputs: pick_oh[N], pick_any.
//     - Implementation: double-width mask-and-priority.
//   - Top module holds the FSM, ptr, hold_cnt and output registers.
// TESTING  (N=8, MAX_HOLD=4, clk period 10)
//   1. Reset: reset=0 for 2 edges with req=8'hFF -> gnt=0, gnt_valid=0, gnt_id=0, ptr=8'h01.
//   2. Sole requester: req=8'h04 held -> gnt=8'h04 one edge later and stays continuously
//      (re-grant at hold limit, no bubble); ptr=8'h08 after the 4th grant cycle.
//   3. Full load: req=8'hFF after reset -> gnt_id 0,1,...,7,0.
//      Each id lasts exactly 4 cycles; gnt_valid never drops.
//   4. Early release: req=8'h81; clear req[0] after 2 grant cycles -> gnt=8'h01 for 2 cycles,
//      then 8'h80 on the next edge.
//   5. Wrap: after client 6 releases (ptr=8'h80), req=8'h41 -> gnt=8'h01 (7 empty, wraps to 0).
//      Then gnt=8'h40 after client 0 releases.
//   6. Reset mid-grant: gnt=8'h10 active, reset=0 one edge -> gnt=0, ptr=8'h01.
//      Then reset=1 with req=8'h10 -> gnt=8'h10 one edge later.
//   - All tests: assert every cycle that $onehot0(gnt), $onehot(ptr), and gnt_id matches gnt.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
package ring_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Index of the set bit in a one-hot vector; returns 0 for an all-zero vector.
  function automatic int unsigned onehot2idx(input logic [63:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 64; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority picker: first set req bit at or above ptr, wrapping around.
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick_oh,
  output logic         pick_any
);

  logic [2*N-1:0] dbl, first;

  // Lower half keeps only bits at/above ptr; upper half supplies the wrapped copy.
  always_comb begin
    dbl      = {req, req & ~(ptr - N'(1))};
    first    = dbl & (~dbl + (2*N)'(1));
    pick_oh  = first[N-1:0] | first[2*N-1:N];
    pick_any = |req;
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with one-hot ring pointer, bounded hold and bubble-free handover.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic [N-1:0]         ptr
);

  localparam int HW = $clog2(MAX_HOLD) + 1;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           rel;
  logic [N-1:0]   ptr_rot, pick_ptr, pick_oh;
  logic           pick_any;

  assign ptr_rot  = {gnt_q[N-2:0], gnt_q[N-1]};
  assign rel      = ~|(req & gnt_q) || (hold_q == HW'(MAX_HOLD - 1));
  // On release the search starts just past the owner in the same cycle.
  assign pick_ptr = (state_q == ST_GRANT && rel) ? ptr_rot : ptr_q;

  rr_pick #(.N(N)) u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .pick_oh  (pick_oh),
    .pick_any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_any) begin
          gnt_d   = pick_oh;
          hold_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!rel) begin
          hold_d = hold_q + HW'(1);
        end else begin
          ptr_d  = ptr_rot;
          hold_d = '0;
          if (pick_any) begin
            gnt_d = pick_oh;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= N'(1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = $clog2(N)'(onehot2idx(64'(gnt_q)));
  assign ptr       = ptr_q;

endmodule
